// File: rtl/div_pkg.sv
// Shared state encoding and sizing constants for the iterative MIPS DIV/DIVU unit.
package div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_CYCLES = DIV_WIDTH;
    localparam int DIV_CNT_W  = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// Chaining two instances gives a radix-4-per-cycle variant without touching this file.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dividend_shift_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dividend_shift_o
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;
    logic           q_bit;

    // The extra top bit of the trial is its sign: set means the divisor did not fit.
    assign rem_shift        = {rem_i, dividend_shift_i[WIDTH-1]};
    assign trial            = rem_shift - {1'b0, divisor_i};
    assign q_bit            = ~trial[WIDTH];
    assign rem_o            = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign dividend_shift_o = {dividend_shift_i[WIDTH-2:0], q_bit};

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU in EX; drives the EX stall
// request and delivers {HI=remainder, LO=quotient} as a one-cycle valid pulse.
module div_iter_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_en,
    input  logic               div_signed,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic               flush,
    output logic               div_stall,
    output logic [2*WIDTH-1:0] div_result,
    output logic               div_result_valid
);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               valid_q, valid_d;

    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   dvd_nx;
    logic               opa_neg;
    logic               opb_neg;
    logic [WIDTH-1:0]   opa_mag;
    logic [WIDTH-1:0]   opb_mag;
    logic               last_iter;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i            (rem_q),
        .dividend_shift_i (dvd_q),
        .divisor_i        (dsr_q),
        .rem_o            (rem_nx),
        .dividend_shift_o (dvd_nx)
    );

    // The core works on magnitudes; signs are re-applied once at completion.
    assign opa_neg   = div_signed & opa[WIDTH-1];
    assign opb_neg   = div_signed & opb[WIDTH-1];
    assign opa_mag   = opa_neg ? -opa : opa;
    assign opb_mag   = opb_neg ? -opb : opb;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Stall must be visible in the start cycle itself, and drops in DONE so EX can advance.
    assign div_stall        = ~rst & div_en & ~flush & (state_q != DIV_DONE);
    assign div_result       = result_q;
    assign div_result_valid = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    // Flush wins over everything; losing div_en mid-divide means the EX op was annulled.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        valid_d  = 1'b0;

        if (flush) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (div_en) begin
                        state_d = DIV_BUSY;
                        cnt_d   = '0;
                        rem_d   = '0;
                        dvd_d   = opa_mag;
                        dsr_d   = opb_mag;
                        q_neg_d = opa_neg ^ opb_neg;
                        r_neg_d = opa_neg;
                    end
                end
                DIV_BUSY: begin
                    if (!div_en) begin
                        state_d = DIV_IDLE;
                    end else begin
                        rem_d = rem_nx;
                        dvd_d = dvd_nx;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (last_iter) begin
                            state_d  = DIV_DONE;
                            result_d = {(r_neg_q ? -rem_nx : rem_nx),
                                        (q_neg_q ? -dvd_nx : dvd_nx)};
                            valid_d  = 1'b1;
                        end
                    end
                end
                DIV_DONE: begin
                    state_d = DIV_IDLE;
                end
                default: begin
                    state_d = DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed corner cases plus randomized
// divides compared against an arithmetic reference built on 64-bit integer division.
module tb_div_iter_unit;

    logic        clk;
    logic        rst;
    logic        div_en;
    logic        div_signed;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        div_stall;
    logic [63:0] div_result;
    logic        div_result_valid;

    int          vectors;
    int          miscompares;
    logic [63:0] lastExp;

    div_iter_unit dut (
        .clk              (clk),
        .rst              (rst),
        .div_en           (div_en),
        .div_signed       (div_signed),
        .opa              (opa),
        .opb              (opb),
        .flush            (flush),
        .div_stall        (div_stall),
        .div_result       (div_result),
        .div_result_valid (div_result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference: truncating integer division on 64-bit values; divide-by-zero
    // yields an all-ones magnitude quotient and the dividend magnitude as remainder.
    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [31:0] qLo;
        logic [31:0] rHi;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        if (sb == 0) begin
            qLo = 32'hFFFF_FFFF;
            rHi = (sa < 0) ? 32'(-sa) : 32'(sa);
            if (sa < 0) begin
                qLo = -qLo;
                rHi = -rHi;
            end
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            qLo = q[31:0];
            rHi = r[31:0];
        end
        return {rHi, qLo};
    endfunction

    // Runs one divide with div_en held, scrambling operands once latched, and
    // checks stall length, DONE-cycle stall, result and (optionally) the pulse width.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn, input bit dropEn);
        int   stallCount;
        int   cycles;
        bit   gotValid;
        logic lastStall;
        stallCount = 0;
        cycles     = 0;
        gotValid   = 1'b0;
        lastExp    = refDiv(a, b, sgn);
        @(negedge clk);
        opa        = a;
        opb        = b;
        div_signed = sgn;
        div_en     = 1'b1;
        flush      = 1'b0;
        while (!gotValid && cycles < 80) begin
            #1;
            lastStall = div_stall;
            if (div_stall) stallCount++;
            @(posedge clk);
            #1;
            cycles++;
            if (div_result_valid) begin
                gotValid = 1'b1;
            end else if (lastStall) begin
                opa        = $urandom;
                opb        = $urandom;
                div_signed = 1'($urandom_range(0, 1));
            end
        end
        checkOutput("valid_seen", 64'(gotValid), 64'd1);
        checkOutput("stall_cycles", 64'(stallCount), 64'd33);
        #1;
        checkOutput("stall_in_done", 64'(div_stall), 64'd0);
        checkOutput("result", div_result, lastExp);
        if (dropEn) begin
            @(negedge clk);
            div_en = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("valid_one_cycle", 64'(div_result_valid), 64'd0);
            checkOutput("result_hold", div_result, lastExp);
        end
    endtask

    // Starts a divide and returns during the given BUSY cycle index (post-edge).
    task automatic startAndRun(input logic [31:0] a, input logic [31:0] b, input int busyCycles);
        @(negedge clk);
        opa        = a;
        opb        = b;
        div_signed = 1'b0;
        div_en     = 1'b1;
        flush      = 1'b0;
        @(posedge clk);
        repeat (busyCycles) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        vectors     = 0;
        miscompares = 0;
        lastExp     = '0;

        // Reset values, with div_en high to show the stall is masked by rst.
        rst        = 1'b1;
        div_en     = 1'b1;
        div_signed = 1'b0;
        opa        = 32'd100;
        opb        = 32'd7;
        flush      = 1'b0;
        #12;
        checkOutput("rst_stall", 64'(div_stall), 64'd0);
        checkOutput("rst_valid", 64'(div_result_valid), 64'd0);
        checkOutput("rst_result", div_result, 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        div_en = 1'b0;

        $display("[TB] directed divides");
        applyStimulus(32'd100, 32'd7, 1'b0, 1'b1);
        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
        applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        applyStimulus(32'd5, 32'd0, 1'b0, 1'b1);
        applyStimulus(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);

        $display("[TB] back-to-back");
        applyStimulus(32'd20, 32'd3, 1'b0, 1'b0);
        applyStimulus(32'd9, 32'd4, 1'b0, 1'b1);

        $display("[TB] flush mid-divide, then div_en dropped");
        held = lastExp;
        startAndRun(32'd1000, 32'd9, 10);
        flush = 1'b1;
        #1;
        checkOutput("stall_during_flush", 64'(div_stall), 64'd0);
        @(posedge clk);
        #1;
        flush  = 1'b0;
        div_en = 1'b0;
        #1;
        checkOutput("stall_after_flush", 64'(div_stall), 64'd0);
        checkOutput("valid_after_flush", 64'(div_result_valid), 64'd0);
        checkOutput("result_after_flush", div_result, held);
        applyStimulus(32'd77, 32'd5, 1'b0, 1'b1);

        $display("[TB] flush with div_en held restarts from scratch");
        startAndRun(32'd500, 32'd3, 5);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        applyStimulus(32'd123456, 32'd789, 1'b0, 1'b1);

        $display("[TB] flush beats start in IDLE");
        @(negedge clk);
        opa    = 32'd40;
        opb    = 32'd6;
        div_en = 1'b1;
        flush  = 1'b1;
        #1;
        checkOutput("stall_flush_start", 64'(div_stall), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        applyStimulus(32'd41, 32'd6, 1'b0, 1'b1);

        $display("[TB] div_en dropped mid-divide aborts");
        startAndRun(32'd999, 32'd10, 4);
        div_en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("valid_after_abort", 64'(div_result_valid), 64'd0);
        applyStimulus(32'd64, 32'd8, 1'b0, 1'b1);

        $display("[TB] async reset mid-divide");
        startAndRun(32'd31337, 32'd17, 6);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_stall", 64'(div_stall), 64'd0);
        checkOutput("arst_valid", 64'(div_result_valid), 64'd0);
        checkOutput("arst_result", div_result, 64'd0);
        @(posedge clk);
        #1;
        checkOutput("arst_hold_result", div_result, 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        div_en = 1'b0;
        applyStimulus(32'hFFFF_FF00, 32'd16, 1'b1, 1'b1);

        $display("[TB] randomized divides");
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: rb = 32'($urandom_range(0, 5));
                1: ra = 32'h8000_0000;
                2: rb = rb >> $urandom_range(1, 31);
                default: ;
            endcase
            applyStimulus(ra, rb, rs, 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        div_en = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
Multi-cycle radix-2 restoring divider in the EX stage, executing MIPS DIV/DIVU. It produces the stall request the hazard unit consumes as div_stallE, which holds F/D/E and bubbles M until the quotient and remainder are ready. It is the producer end of the stall/flush handshake: it honours the exception flush, and its result goes to the HI/LO write path.

Parameters:
WIDTH, 32, operand width; the result is 2*WIDTH bits, {remainder, quotient}.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
div_en  in  1  a DIV/DIVU occupies EX this cycle (valid, not bubbled)
div_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled at start
opa  in  WIDTH  dividend (rs value after forwarding); sampled at start
opb  in  WIDTH  divisor (rt value after forwarding); sampled at start
flush  in  1  cancel the in-flight divide (flush_exceptionM)
div_stall  out  1  stall request, combinational; becomes div_stallE
div_result  out  2*WIDTH  {HI=remainder, LO=quotient}, registered
div_result_valid  out  1  one-cycle pulse; the result is valid this cycle

Behaviour:
- States: IDLE, BUSY, DONE. Encoding is in the package.
- Reset (async): state=IDLE, counter=0, div_result=0, div_result_valid=0. div_stall is forced to 0 while rst is high.
- div_stall = div_en & ~flush & (state != DONE). It is asserted in the start cycle, with no cycle of lag.
- IDLE: if div_en & ~flush, latch |opa|, |opb|, the quotient sign (opa[MSB]^opb[MSB])&div_signed, and the remainder sign opa[MSB]&div_signed; clear the partial remainder and counter; go to BUSY.
- BUSY: each cycle performs one restoring step.
  - Shift {rem, dividend} left by 1.
  - Trial = rem - divisor, computed WIDTH+1 bits wide.
  - If the trial is non-negative, rem = trial and shift in quotient bit 1; otherwise shift in 0.
  - Counter increments. After iteration WIDTH-1, the next state is DONE.
  - Latency is fixed at WIDTH cycles in BUSY, with no early termination.
- Transition into DONE: apply the sign fixup (negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set). Register div_result and set div_result_valid for exactly one cycle.
- DONE: div_stall=0, so EX advances with the result this cycle. Next state is unconditionally IDLE; div_result holds its value and valid drops.
- Total for WIDTH=32: div_stall high for 33 consecutive cycles (the start cycle plus 32 BUSY cycles); the result appears on cycle 34.
- flush in any state: next state is IDLE, no valid pulse, div_result unchanged. flush has priority over start in the same cycle.
- div_en deasserted while in BUSY (EX entry annulled): abort to IDLE with no valid pulse.
- Back-to-back divides: the cycle after DONE is IDLE. If div_en is high there, a new divide starts.
- Divide by zero (architecturally UNPREDICTABLE; defined here for determinism), unsigned path: LO=all ones, HI=|opa|, then the sign fixup is applied.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0. This falls out of the magnitude arithmetic and is not special-cased.
- Operand changes during BUSY are ignored, because the operands are latched at start.

Decomposition:
- Package div_pkg:
  - state enum: DIV_IDLE, DIV_BUSY, DIV_DONE
  - DIV_WIDTH=32
  - DIV_CYCLES=DIV_WIDTH
- Sub-module div_step: purely combinational, one restoring iteration.
  - Inputs: rem, dividend_shift, divisor.
  - Outputs: next rem, next dividend_shift (with the quotient bit inserted).
  - Lets a future radix-4 variant instantiate two steps per cycle.

Test Plan:
- DIVU 100/7, div_en held → div_stall high for 33 cycles; div_result={32'd2, 32'd14}; valid pulses once; stall low in the DONE cycle.
- DIV -7/2 (0xFFFFFFF9, 2) → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIV 7/-2 → LO=-3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
- Start a divide, assert flush at BUSY cycle 10 → next cycle IDLE, div_stall=0, no valid pulse, div_result holds its old value. A new div_en the following cycle restarts the full 33-cycle stall.
- rst asserted mid-BUSY (asynchronously, between clock edges) → state, valid and result immediately 0; div_stall 0 while rst is high.
- Two DIVUs back to back (20/3, then 9/4) → two valid pulses one IDLE cycle apart in between, results {2,6} then {1,2}; stall 33 cycles each.
